controle_repor_rolhas: RTL and testbench
========================================

Name: controle_repor_rolhas

Overview:
- Cork-stock supply controller for the capping station. It consumes "cork used" events, keeps the cork stock as a two-digit BCD count (00-99) and requests batches from the feeder through a req/ack handshake.
- It adds each delivered batch to the stock one unit per clock.
- The BCD outputs drive the existing 7-segment digit decoders.
- Its status outputs stall the line when the stock is empty.

Parameters:
- ESTOQUE_INI, 20: stock loaded at reset, decimal 0-99.
- LIMIAR, 5: a refill is requested when stock <= LIMIAR, decimal 0-98.
- LOTE, 15: units delivered per acknowledged batch, decimal 1-99.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces the reset state immediately.
- usa_rolha  in  1  level from the capper, synchronous to clock; each rising edge consumes one cork.
- ack_repor  in  1  feeder acknowledge, level; sampled only while req_repor=1.
- req_repor  out  1  refill request to the feeder.
- unid  out  4  stock units digit, BCD.
- dez  out  4  stock tens digit, BCD.
- sem_rolha  out  1  high while stock == 00.
- repondo  out  1  high while a batch is being added.
- erro_vazio  out  1  one-cycle pulse when a consume event arrives at stock 00.

Behaviour:
- Reset values: stock = ESTOQUE_INI (as BCD), state NORMAL, req_repor=0, repondo=0, erro_vazio=0, usa_q=0, lote count=0. sem_rolha=1 only if ESTOQUE_INI=0.
- Edge detect: consume pulse c = usa_rolha & ~usa_q, where usa_q is usa_rolha registered.
  - The stock decrements on the same edge where the high level is first sampled.
  - A held level counts once.
- Arithmetic: stock is always valid BCD, range 00-99.
  - Decrement: 10 -> 09, 01 -> 00.
  - Increment: 09 -> 10, 98 -> 99.
  - Decrement at 00: stock holds 00 and erro_vazio pulses on the next cycle. This is a registered output, high for exactly one cycle.
  - Increment at 99: stock holds 99 (saturates). The batch cycle is still consumed and no error is flagged.
- The FSM is registered and has three states:
  - NORMAL:
    - Stock changes by c only.
    - If stock <= LIMIAR, go to PEDINDO on the next edge; req_repor=1 from that cycle.
  - PEDINDO:
    - req_repor=1 and consumption continues.
    - When ack_repor=1 is sampled, go to REPONDO. req_repor drops and repondo rises in the same cycle (registered).
    - The lote count is loaded with LOTE.
  - REPONDO:
    - Each cycle, stock +1 (saturating) and the lote count decrements.
    - If c fires in the same cycle, +1 and -1 cancel and the stock holds. At 00, the +1 applies with no error.
    - When the lote count reaches 1, the last increment is applied and the FSM returns to NORMAL. A batch therefore spans exactly LOTE cycles with repondo=1.
- After a refill, if stock <= LIMIAR still holds, NORMAL re-requests on the next cycle.
- ack_repor is ignored in NORMAL and REPONDO. ack held high across batches does not start a second batch until a fresh request has been raised (minimum one PEDINDO cycle).
- sem_rolha is a decode of the registered stock; it changes in the same cycle the stock changes.
- A reset asserted mid-request or mid-batch aborts it: req_repor and repondo drop asynchronously and the stock returns to ESTOQUE_INI.
- There is no combinational path from any input to any output.

Decomposition:
- Shared package rolhas_pkg holds:
  - the state enum (NORMAL, PEDINDO, REPONDO);
  - the BCD digit type;
  - functions bcd_inc_sat and bcd_dec_sat over the {dez,unid} pair;
  - a constant converting decimal to BCD, used for ESTOQUE_INI and LIMIAR.
- One sub-module is natural: bcd_estoque_0_99, the up/down saturating two-digit BCD register with inc/dec inputs and a load value. The FSM and edge detector stay in the top.

Test Plan:
- Reset with defaults -> dez=2, unid=0, req_repor=0, repondo=0, sem_rolha=0. Reset asserted between edges clears the outputs immediately.
- 15 separate usa_rolha pulses -> stock 05. req_repor=1 one cycle after the 15th decrement. Holding usa_rolha high for 10 cycles decrements only once.
- From PEDINDO at 05, assert ack_repor for 1 cycle -> req_repor=0 and repondo=1 the next cycle. Stock reaches 20 after exactly 15 cycles, then repondo=0 and req_repor stays 0.
- Drain to 00 with ack_repor tied 0 -> sem_rolha=1 and req_repor=1. A further consume pulse -> stock stays 00 and erro_vazio=1 for one cycle.
- During REPONDO, issue consume pulses on cycles 3 and 7 of the batch -> final stock = 05+15-2 = 18. No erro_vazio.
- ESTOQUE_INI=93, LIMIAR=95, LOTE=15: request and ack -> stock saturates at 99. repondo lasts 15 cycles, then the FSM returns to NORMAL without requesting.

Source files
------------

// File: rtl/rolhas_pkg.sv
// rolhas_pkg
// Shared types and helpers for the cork-stock supply controller.
//   estado_t       : refill FSM states (NORMAL, PEDINDO, REPONDO)
//   bcd_digito_t   : one BCD digit (0-9)
//   dec_para_bcd   : decimal 0-99 -> packed {dez,unid} BCD pair (constant use)
//   bcd_inc_sat    : +1 on a {dez,unid} pair, saturating at 99
//   bcd_dec_sat    : -1 on a {dez,unid} pair, saturating at 00
package rolhas_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    PEDINDO = 2'd1,
    REPONDO = 2'd2
  } estado_t;

  typedef logic [3:0] bcd_digito_t;

  localparam logic [7:0] BCD_MAX = 8'h99;
  localparam logic [7:0] BCD_MIN = 8'h00;

  function automatic logic [7:0] dec_para_bcd(input int valor);
    bcd_digito_t d;
    bcd_digito_t u;
    d = 4'(valor / 10);
    u = 4'(valor % 10);
    return {d, u};
  endfunction

  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] par);
    logic [7:0] r;
    if (par == BCD_MAX)
      r = par;
    else if (par[3:0] == 4'd9)
      r = {par[7:4] + 4'd1, 4'd0};
    else
      r = {par[7:4], par[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec_sat(input logic [7:0] par);
    logic [7:0] r;
    if (par == BCD_MIN)
      r = par;
    else if (par[3:0] == 4'd0)
      r = {par[7:4] - 4'd1, 4'd9};
    else
      r = {par[7:4], par[3:0] - 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_estoque_0_99.sv
// bcd_estoque_0_99
// Up/down saturating two-digit BCD register (00-99).
//   clock     : system clock, rising edge
//   reset     : asynchronous, active-high; loads VALOR_INI
//   inc, dec  : +1 / -1 request for this edge
//   dez, unid : registered tens / units digits
// When inc and dec arrive together the decrement is applied first (saturating)
// and then the increment, so the pair cancels except at 00, where the result
// is 01: a consume at empty stock is absorbed by the saturation and the
// delivered unit still lands.
module bcd_estoque_0_99
  import rolhas_pkg::*;
#(
  parameter logic [7:0] VALOR_INI = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  input  logic        dec,
  output bcd_digito_t dez,
  output bcd_digito_t unid
);

  logic [7:0] estoque_reg;
  logic [7:0] estoque_next;

  always_comb begin
    estoque_next = estoque_reg;
    case ({inc, dec})
      2'b10:   estoque_next = bcd_inc_sat(estoque_reg);
      2'b01:   estoque_next = bcd_dec_sat(estoque_reg);
      2'b11:   estoque_next = bcd_inc_sat(bcd_dec_sat(estoque_reg));
      default: estoque_next = estoque_reg;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      estoque_reg <= VALOR_INI;
    else
      estoque_reg <= estoque_next;
  end

  assign dez  = estoque_reg[7:4];
  assign unid = estoque_reg[3:0];

endmodule

// File: rtl/controle_repor_rolhas.sv
// controle_repor_rolhas
// Cork-stock supply controller for the capping station.
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high
//   usa_rolha  : capper level; each rising edge consumes one cork
//   ack_repor  : feeder acknowledge, only looked at while req_repor=1
//   req_repor  : refill request to the feeder
//   unid, dez  : stock as BCD digits (drive the 7-segment decoders)
//   sem_rolha  : stock is 00
//   repondo    : a batch is being added, one unit per clock
//   erro_vazio : one-cycle pulse after a consume arrived at stock 00
// All outputs come from registers; no input reaches an output combinationally.
module controle_repor_rolhas
  import rolhas_pkg::*;
#(
  parameter int ESTOQUE_INI = 20,
  parameter int LIMIAR      = 5,
  parameter int LOTE        = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        usa_rolha,
  input  logic        ack_repor,
  output logic        req_repor,
  output logic [3:0]  unid,
  output logic [3:0]  dez,
  output logic        sem_rolha,
  output logic        repondo,
  output logic        erro_vazio
);

  localparam logic [7:0] ESTOQUE_INI_BCD = dec_para_bcd(ESTOQUE_INI);
  localparam logic [7:0] LIMIAR_BCD      = dec_para_bcd(LIMIAR);
  localparam logic [6:0] LOTE_CNT        = 7'(LOTE);

  estado_t     estado_reg;
  estado_t     estado_next;
  logic        usa_q_reg;
  logic [6:0]  lote_reg;
  logic [6:0]  lote_next;
  logic        erro_reg;
  logic        erro_next;
  logic        consumo;
  logic        inc;
  bcd_digito_t dez_w;
  bcd_digito_t unid_w;
  logic [7:0]  estoque;

  // Rising-edge detect on the capper level: a held level counts once.
  assign consumo = usa_rolha & ~usa_q_reg;

  assign estoque = {dez_w, unid_w};

  bcd_estoque_0_99 #(
    .VALOR_INI (ESTOQUE_INI_BCD)
  ) u_estoque (
    .clock (clock),
    .reset (reset),
    .inc   (inc),
    .dec   (consumo),
    .dez   (dez_w),
    .unid  (unid_w)
  );

  always_comb begin
    estado_next = estado_reg;
    lote_next   = lote_reg;
    inc         = 1'b0;
    case (estado_reg)
      NORMAL: begin
        // Packed BCD keeps numeric order, so a plain compare works.
        if (estoque <= LIMIAR_BCD)
          estado_next = PEDINDO;
      end
      PEDINDO: begin
        if (ack_repor) begin
          estado_next = REPONDO;
          lote_next   = LOTE_CNT;
        end
      end
      REPONDO: begin
        inc       = 1'b1;
        lote_next = lote_reg - 7'd1;
        if (lote_reg <= 7'd1) begin
          estado_next = NORMAL;
          lote_next   = 7'd0;
        end
      end
      default: begin
        estado_next = NORMAL;
        lote_next   = 7'd0;
      end
    endcase
    // Only a consume that is not paired with a batch increment can underflow.
    erro_next = consumo & ~inc & (estoque == BCD_MIN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_reg <= NORMAL;
      lote_reg   <= 7'd0;
      usa_q_reg  <= 1'b0;
      erro_reg   <= 1'b0;
    end else begin
      estado_reg <= estado_next;
      lote_reg   <= lote_next;
      usa_q_reg  <= usa_rolha;
      erro_reg   <= erro_next;
    end
  end

  assign req_repor  = (estado_reg == PEDINDO);
  assign repondo    = (estado_reg == REPONDO);
  assign erro_vazio = erro_reg;
  assign sem_rolha  = (estoque == BCD_MIN);
  assign dez        = dez_w;
  assign unid       = unid_w;

endmodule

// File: tb/tb_controle_repor_rolhas.sv
// tb_controle_repor_rolhas
// Two instances share the inputs: dut0 uses the default parameters,
// dut1 uses ESTOQUE_INI=93, LIMIAR=95, LOTE=15 to exercise saturation.
// A cycle-level reference model (integer stock, request flag, units left in
// batch) runs alongside both and is compared after every clock.
module tb_controle_repor_rolhas;

  logic clock;
  logic reset;
  logic usa_rolha;
  logic ack_repor;

  logic       req0, sem0, rep0, err0;
  logic [3:0] dez0, unid0;
  logic       req1, sem1, rep1, err1;
  logic [3:0] dez1, unid1;

  int total = 0;
  int bad   = 0;

  controle_repor_rolhas dut0 (
    .clock      (clock),
    .reset      (reset),
    .usa_rolha  (usa_rolha),
    .ack_repor  (ack_repor),
    .req_repor  (req0),
    .unid       (unid0),
    .dez        (dez0),
    .sem_rolha  (sem0),
    .repondo    (rep0),
    .erro_vazio (err0)
  );

  controle_repor_rolhas #(
    .ESTOQUE_INI (93),
    .LIMIAR      (95),
    .LOTE        (15)
  ) dut1 (
    .clock      (clock),
    .reset      (reset),
    .usa_rolha  (usa_rolha),
    .ack_repor  (ack_repor),
    .req_repor  (req1),
    .unid       (unid1),
    .dez        (dez1),
    .sem_rolha  (sem1),
    .repondo    (rep1),
    .erro_vazio (err1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state, index 0 -> dut0, 1 -> dut1
  int m_ini   [2] = '{20, 93};
  int m_lim   [2] = '{5, 95};
  int m_lote  [2] = '{15, 15};
  int m_stock [2];
  int m_left  [2];
  bit m_req   [2];
  bit m_err   [2];
  bit m_usa_q [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_stock[k] = m_ini[k];
      m_left[k]  = 0;
      m_req[k]   = 1'b0;
      m_err[k]   = 1'b0;
      m_usa_q[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(input int k, input bit u, input bit a);
    bit c;
    int s;
    c = u && !m_usa_q[k];
    s = m_stock[k];
    m_usa_q[k] = u;
    m_err[k] = 1'b0;
    if (m_left[k] > 0) begin
      // batch unit arrives; a simultaneous consume eats it
      if (!c)
        s = (s < 99) ? s + 1 : 99;
      else if (s == 0)
        s = 1;
      m_left[k] = m_left[k] - 1;
    end else begin
      if (c) begin
        if (s == 0) m_err[k] = 1'b1;
        else        s = s - 1;
      end
      if (m_req[k]) begin
        if (a) begin
          m_req[k]  = 1'b0;
          m_left[k] = m_lote[k];
        end
      end else if (m_stock[k] <= m_lim[k]) begin
        m_req[k] = 1'b1;
      end
    end
    m_stock[k] = s;
  endfunction

  task automatic chk(input string nome, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", nome, got, exp, $time);
    end
  endtask

  task automatic check_model(input int k);
    logic [3:0] d, u;
    logic r, p, s, e;
    d = k ? dez1 : dez0;   u = k ? unid1 : unid0;
    r = k ? req1 : req0;   p = k ? rep1 : rep0;
    s = k ? sem1 : sem0;   e = k ? err1 : err0;
    chk($sformatf("dut%0d.dez", k),        int'(d), m_stock[k] / 10);
    chk($sformatf("dut%0d.unid", k),       int'(u), m_stock[k] % 10);
    chk($sformatf("dut%0d.req_repor", k),  int'(r), int'(m_req[k]));
    chk($sformatf("dut%0d.repondo", k),    int'(p), int'(m_left[k] > 0));
    chk($sformatf("dut%0d.sem_rolha", k),  int'(s), int'(m_stock[k] == 0));
    chk($sformatf("dut%0d.erro_vazio", k), int'(e), int'(m_err[k]));
  endtask

  // Inputs are applied at posedge+1 and sampled by the DUT at the next edge.
  task automatic step(input bit u, input bit a);
    usa_rolha = u;
    ack_repor = a;
    @(posedge clock);
    model_step(0, u, a);
    model_step(1, u, a);
    #1;
    check_model(0);
    check_model(1);
  endtask

  task automatic do_reset();
    usa_rolha = 1'b0;
    ack_repor = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_model(0);
    check_model(1);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit usa;
    bit ack;
    int n;
    int stock;
    bit req;
    bit rep;
    bit err;
  } vec_t;

  vec_t tab[$];

  initial begin
    int cnt;
    reset = 1'b0;
    usa_rolha = 1'b0;
    ack_repor = 1'b0;
    #1;

    // ---- reset state ----
    do_reset();
    chk("rst_dez", int'(dez0), 2);
    chk("rst_unid", int'(unid0), 0);
    chk("rst_req", int'(req0), 0);
    chk("rst_rep", int'(rep0), 0);
    chk("rst_sem", int'(sem0), 0);

    // ---- table: 15 pulses to 05, request, one-cycle ack, batch to 20 ----
    tab.push_back('{1, 0, 1, 19, 0, 0, 0});
    tab.push_back('{1, 0, 9, 19, 0, 0, 0});   // held level: no further decrement
    tab.push_back('{0, 0, 1, 19, 0, 0, 0});
    for (int i = 0; i < 14; i++) begin
      tab.push_back('{1, 0, 1, 18 - i, 0, 0, 0});
      tab.push_back('{0, 0, 1, 18 - i, (i == 13), 0, 0});
    end
    tab.push_back('{0, 1, 1, 5, 0, 1, 0});
    tab.push_back('{0, 0, 14, 19, 0, 1, 0});
    tab.push_back('{0, 0, 1, 20, 0, 0, 0});
    tab.push_back('{0, 0, 3, 20, 0, 0, 0});
    foreach (tab[i]) begin
      repeat (tab[i].n) step(tab[i].usa, tab[i].ack);
      chk($sformatf("vec%0d.stock", i), int'(dez0) * 10 + int'(unid0), tab[i].stock);
      chk($sformatf("vec%0d.req", i), int'(req0), int'(tab[i].req));
      chk($sformatf("vec%0d.rep", i), int'(rep0), int'(tab[i].rep));
      chk($sformatf("vec%0d.err", i), int'(err0), int'(tab[i].err));
      $display("vec %0d usa=%0d ack=%0d n=%0d stock=%0d%0d req=%0d rep=%0d",
               i, tab[i].usa, tab[i].ack, tab[i].n, dez0, unid0, req0, rep0);
    end

    // ---- consumes on batch cycles 3 and 7 ----
    do_reset();
    repeat (15) begin step(1, 0); step(0, 0); end
    step(0, 0);
    chk("cons_req", int'(req0), 1);
    step(0, 1);
    for (int j = 1; j <= 15; j++) begin
      step(j == 3 || j == 7, 0);
      chk("cons_noerr", int'(err0), 0);
    end
    chk("cons_stock", int'(dez0) * 10 + int'(unid0), 18);
    chk("cons_rep_end", int'(rep0), 0);
    $display("seq consume-during-batch stock=%0d%0d", dez0, unid0);

    // ---- drain to 00 with no ack, then underflow ----
    repeat (18) begin step(1, 0); step(0, 0); end
    chk("drain_sem", int'(sem0), 1);
    chk("drain_req", int'(req0), 1);
    step(1, 0);
    chk("under_stock", int'(dez0) * 10 + int'(unid0), 0);
    chk("under_err", int'(err0), 1);
    step(0, 0);
    chk("under_err_clr", int'(err0), 0);
    $display("seq drain/underflow stock=%0d%0d", dez0, unid0);

    // ---- asynchronous reset in the middle of a batch ----
    step(0, 1);
    step(0, 0);
    chk("mid_rep", int'(rep0), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rep", int'(rep0), 0);
    chk("async_req", int'(req0), 0);
    chk("async_dez", int'(dez0), 2);
    chk("async_unid", int'(unid0), 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    $display("seq async reset mid-batch");

    // ---- saturation on dut1 (93, limit 95) ----
    do_reset();
    step(0, 0);
    chk("sat_req", int'(req1), 1);
    step(0, 1);
    cnt = 0;
    for (int w = 0; w < 40 && rep1; w++) begin
      cnt++;
      step(0, 0);
    end
    chk("sat_rep_len", cnt, 15);
    chk("sat_stock", int'(dez1) * 10 + int'(unid1), 99);
    repeat (3) step(0, 0);
    chk("sat_noreq", int'(req1), 0);
    $display("seq saturation rep_cycles=%0d stock=%0d%0d", cnt, dez1, unid1);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i < 1500)
        step($urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0);
      else
        step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
    end
    $display("random 3000 cycles done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
